serial_ripple_subtractor: RTL and testbench
===========================================

# serial_ripple_subtractor

Bit-serial subtractor computing `a - b - bin` one bit per clock, LSB first, with a registered borrow chain. It is the counterpart to the combinational ripple-carry adder and reuses the same operand and borrow-in/borrow-out conventions. It sits behind a valid/ready handshake so a pipeline stage or test sequencer can feed it back-to-back.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal values are 2 and up.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands on `a`, `b`, `bin` are valid.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: `diff` and `bout` hold the final result.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: difference, modulo 2^WIDTH.
- `bout` output 1: borrow-out. It is 1 when the unsigned value of `a` is less than `b + bin`.
- `ovf` output 1: signed overflow. Present only when `SUB_OVF_EN` is defined.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. `in_valid` moves to RUN.
  - RUN: lasts exactly WIDTH cycles. Moves to DONE after bit WIDTH-1.
  - DONE: `out_valid`=1. `out_ready` moves to IDLE.
- Accept (IDLE, `in_valid`=1):
  - latch `a`, `b` into shift registers;
  - borrow register = `bin`;
  - bit index = 0;
  - clear the `diff` register.
- Each RUN cycle, for bit i = index, with x=a[i], y=b[i], br=borrow:
  - `diff[i]` = x ^ y ^ br;
  - borrow next = (~x & y) | (~(x ^ y) & br);
  - increment index.
  - The index counter is $clog2(WIDTH)+1 bits wide and never wraps within an operation.
- DONE:
  - `bout` = final borrow;
  - `diff`, `bout`, `ovf` stay stable until the handshake completes.
  - Input changes are ignored outside IDLE.
- No bypass: the block cannot accept new operands in the same cycle a result is consumed. New operands are accepted no earlier than the following cycle, from IDLE.
- Reset, including mid-RUN or in DONE:
  - state goes to IDLE; the in-flight operation is discarded;
  - `in_ready`=1 (combinational on state);
  - `out_valid`, `diff`, `bout`, `ovf` all 0.

## Timing
- Handshake at edge k (`in_valid` and `in_ready` both high):
  - RUN occupies edges k+1 … k+WIDTH;
  - `out_valid` is high after edge k+WIDTH.
  - Latency is WIDTH cycles from acceptance.
- `out_valid` and `out_ready` high at edge m: `in_ready` is high after edge m. The next acceptance is at edge m+1 or later.
- Minimum issue interval is WIDTH+2 cycles.
- All outputs are registered except `in_ready`, which is decoded from state.
- `out_valid` may be held indefinitely by a low `out_ready`; the result must not change while held.

## Configuration
- Macro `SUB_OVF_EN`.
- Defined:
  - `ovf` port exists;
  - in DONE, `ovf` = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched operands;
  - `ovf` is 0 outside DONE and after reset.
- Undefined:
  - the port and its logic are removed;
  - all other behaviour is identical.

## Structure
- Package `sub_pkg`:
  - FSM state enum `sub_state_t` {IDLE, RUN, DONE};
  - default width constant `SUB_WIDTH_DEF` = 4.
- Sub-module `full_subtractor` (inputs x, y, br; outputs d, bo): purely combinational, instantiated once in the serial datapath.
- The top level holds the FSM, operand shift registers, borrow register, index counter and the `diff` accumulator.

## Test plan
All scenarios use WIDTH=4.
- Basic: a=1000, b=0011, bin=0 → `diff`=0101, `bout`=0, `out_valid` exactly 4 cycles after acceptance.
- Borrow out: a=0101, b=0111, bin=1 → `diff`=1101, `bout`=1. With `SUB_OVF_EN`, `ovf`=0.
- Borrow-in propagation: a=1010, b=0110, bin=1 → `diff`=0011, `bout`=0. Also a=1111, b=1001, bin=0 → `diff`=0110, `bout`=0.
- Overflow (`SUB_OVF_EN` defined): a=1000, b=0001, bin=0 → `diff`=0111, `bout`=0, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE, toggling `a`, `b`, `in_valid` → `in_ready`=0 throughout, result unchanged. Then `out_ready`=1 → IDLE next cycle.
- Reset mid-operation: assert `rst` during the 2nd RUN cycle → immediately `out_valid`=0, `diff`=0, `in_ready`=1. The next operation (0011-0001, bin=0) yields `diff`=0010.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - br, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);

  // Difference bit and borrow generation/propagation
  always_comb begin
    d  = x ^ y ^ br;
    bo = (~x & y) | (~(x ^ y) & br);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output is built when SUB_OVF_EN is defined.
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             fs_d, fs_bo;
`ifdef SUB_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // Single serial bit slice: operates on the current LSBs of the shifters
  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .br (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Next-state and datapath updates; defaults hold every register
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          diff_d  = '0;
`ifdef SUB_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB and shift down, so bit i lands at
        // position i after WIDTH steps without a variable-index write.
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_bo;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          bout_d  = fs_bo;
`ifdef SUB_OVF_EN
          // fs_d is the final MSB of the difference
          ovf_d   = (amsb_q != bmsb_q) & (fs_d != amsb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
`ifdef SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
// Build with SUB_OVF_EN defined to also check the overflow output.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [W-1:0] a, b, diff;
  logic         ovf_w;

  int checks = 0;
  int errors = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf_w)
`endif
  );

`ifndef SUB_OVF_EN
  assign ovf_w = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent reference: integer subtraction plus the MSB overflow rule
  function automatic vec_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    vec_t v;
    int   r;
    r      = int'(ia) - int'(ib) - int'(ibin);
    v.a    = ia;
    v.b    = ib;
    v.bin  = ibin;
    v.diff = W'(r);
    v.bout = (r < 0);
    v.ovf  = (ia[W-1] != ib[W-1]) && (v.diff[W-1] != ia[W-1]);
    return v;
  endfunction

  // Drive operands at a negedge; acceptance happens on the next posedge
  task automatic accept(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    chk("in_ready_before_accept", in_ready, 1'b1);
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency and compare against the scoreboard
  task automatic collect();
    int   cyc;
    vec_t e;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, W);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("diff", diff, e.diff);
      chk("bout", bout, e.bout);
`ifdef SUB_OVF_EN
      chk("ovf", ovf_w, e.ovf);
`endif
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_consume", in_ready, 1'b1);
    chk("out_valid_after_consume", out_valid, 1'b0);
`ifdef SUB_OVF_EN
    chk("ovf_after_consume", ovf_w, 1'b0);
`endif
  endtask

  task automatic full_op(input vec_t v);
    sb.push_back(v);
    accept(v.a, v.b, v.bin);
    collect();
    consume();
  endtask

  initial begin
    vec_t tbl[8];
    vec_t e;
    logic [W-1:0] hd;
    logic         hb;

    tbl[0] = '{4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b1};
    tbl[1] = '{4'b0101, 4'b0111, 1'b1, 4'b1101, 1'b1, 1'b0};
    tbl[2] = '{4'b1010, 4'b0110, 1'b1, 4'b0011, 1'b0, 1'b1};
    tbl[3] = '{4'b1111, 4'b1001, 1'b0, 4'b0110, 1'b0, 1'b0};
    tbl[4] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[6] = '{4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[7] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, '0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++) full_op(tbl[i]);

    // Random vectors against the reference model
    for (int i = 0; i < 12; i++)
      full_op(model(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));

    // Backpressure: result must hold while inputs wiggle
    e = model(4'b1000, 4'b0011, 1'b0);
    sb.push_back(e);
    accept(e.a, e.b, e.bin);
    collect();
    hd = diff; hb = bout;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_diff", diff, e.diff);
      chk("bp_bout", bout, e.bout);
    end
    chk("bp_diff_held", diff, hd);
    chk("bp_bout_held", bout, hb);
    in_valid = 1'b0;
    consume();

    // No bypass: in_valid high while consuming must not start a new op that edge
    out_ready = 1'b1; a = 4'b0110; b = 4'b0001; bin = 1'b0;
    sb.push_back(model(4'b1001, 4'b0100, 1'b0));
    accept(4'b1001, 4'b0100, 1'b0);
    collect();
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("nobypass_idle", in_ready, 1'b1);
    out_ready = 1'b0;
    sb.push_back(model(4'b0110, 4'b0001, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("nobypass_accepted", in_ready, 1'b0);
    collect();
    consume();

    // Reset during the second RUN cycle discards the operation
    accept(4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_diff", diff, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_ovf", ovf_w, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    full_op('{4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0});

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
